data_in_seq: RTL
================

# data_in_seq

Parametrised input sequencer for the mix layer. It captures one `HID_DIM`-element hidden vector and streams it to the downstream compute array as `DATA_N`-element slices, one slice per accepted beat, under valid/ready flow control. It replaces the fixed four-slice free-running selector with:

- arbitrary slice count;
- zero-padded tail slice;
- backpressure and slice index/last tagging;
- back-to-back vector acceptance.

## Interface

Parameters:
- `N_LEN`, default 16: bits per element.
- `HID_DIM`, default 64: elements per input vector.
- `DATA_N`, default 16: elements per output slice.
- `N_SLICE`, derived as ceil(`HID_DIM`/`DATA_N`): slices per vector.
- `IDX_W`, derived as max(1, clog2(`N_SLICE`)): slice index width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `clear`, in, 1: synchronous abort; returns the block to IDLE.
- `in_valid`, in, 1: `input_data` is valid.
- `in_ready`, out, 1: the block will capture on this cycle.
- `input_data`, in, `HID_DIM*N_LEN`: vector; element k occupies bits [k*N_LEN +: N_LEN].
- `out_valid`, out, 1: a slice is presented.
- `out_ready`, in, 1: the consumer accepts the slice.
- `output_data`, out, `DATA_N*N_LEN`: current slice.
- `out_idx`, out, `IDX_W`: index of the current slice, 0..N_SLICE-1.
- `out_last`, out, 1: high on the final slice of the vector (final pass when repeat is enabled).
- `busy`, out, 1: a vector is held (state STREAM).
- `repeat_n`, in, 8: present only with `DATA_IN_SEQ_REPEAT_EN`; number of passes minus 1.

## Operation

State machine:
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`, latch `input_data` into the vector register, load slice 0 into `output_data`, set `out_idx`=0, go to STREAM.
- STREAM:
  - `out_valid`=1.
  - A beat is accepted when `out_valid && out_ready`.
  - On a beat that is not the last, advance to the next slice. Slice i is elements [i*DATA_N, i*DATA_N+DATA_N-1].
  - On the last beat:
    - if `in_valid`, capture the new vector and present its slice 0 next cycle, staying in STREAM;
    - otherwise go to IDLE and zero `output_data`, `out_idx` and `out_last`.
- `in_ready` = IDLE, or (STREAM && `out_last` && `out_ready`). This is combinational from `out_ready` and is the only combinational path.
- Slice content:
  - Lanes whose element index is ≥ `HID_DIM` (tail slice when `DATA_N` does not divide `HID_DIM`) output zero.
  - No arithmetic on data; bits pass through unchanged.
- Backpressure: while `out_valid && !out_ready`, `output_data`, `out_idx` and `out_last` hold stable.
- `clear` has priority over every handshake:
  - next cycle the block is in IDLE with all outputs zero;
  - a capture coinciding with `clear` is discarded.
- Reset mid-stream: all state is discarded and the block is in IDLE immediately.
- `N_SLICE`=1: every beat is last, and `out_last` stays high whenever `out_valid` is high.

## Timing

- Reset values: `in_ready`=1, `out_valid`=0, `output_data`=0, `out_idx`=0, `out_last`=0, `busy`=0.
- Latency: capture at edge t gives slice 0 valid from cycle t+1.
- Throughput: one slice per cycle with `out_ready` held high. A vector takes N_SLICE cycles, with zero bubbles between back-to-back vectors.
- All outputs except `in_ready` are registered.

## Configuration

- Macro `DATA_IN_SEQ_REPEAT_EN`:
  - Defined:
    - `repeat_n` port exists and is sampled at capture.
    - The vector is streamed `repeat_n`+1 times; `out_idx` wraps N_SLICE-1 → 0 between passes.
    - `out_last` and `in_ready` assert only on the final slice of the final pass.
    - The pass counter is 8 bits, resets to 0, and is cleared by `clear`.
  - Undefined: no `repeat_n` port; exactly one pass per vector.

## Structure

- Shared package/header `consts.vh` holds:
  - `N_LEN`, `HID_DIM`, `DATA_N` defaults;
  - the ceil-divide and clog2 helper functions;
  - the state encoding (IDLE=0, STREAM=1).
- One natural sub-module: `slice_mux`. It is a combinational, zero-padding slice selector driven by the vector and index, reused by other mix-layer feeders.

## Test plan

All scenarios use `N_LEN`=4, `HID_DIM`=8, `DATA_N`=2 unless stated.

- Basic stream:
  - Stimulus: `input_data`=32'h76543210, `in_valid` for 1 cycle, `out_ready`=1.
  - Required: `output_data` 8'h10, 8'h32, 8'h54, 8'h76 on consecutive cycles; `out_idx` 0..3; `out_last` only with 8'h76; then IDLE with `output_data`=0.
- Backpressure:
  - Stimulus: drop `out_ready` for 3 cycles while 8'h32 is presented.
  - Required: 8'h32 and `out_idx`=1 held stable for 3 cycles; no slice lost or duplicated.
- Back-to-back:
  - Stimulus: second vector 32'hFEDCBA98 held on `in_valid`.
  - Required: `in_ready` pulses only with the 8'h76 beat; 8'h98 follows next cycle; 8 consecutive valid beats.
- Zero-pad tail:
  - Stimulus: `HID_DIM`=5, `DATA_N`=2, input 20'h43210.
  - Required: slices 8'h10, 8'h32, 8'h04; `out_last` on the third.
- Clear and reset:
  - Stimulus: assert `clear` while `out_idx`=2; separately assert `rst_n`=0 mid-stream.
  - Required: next cycle `out_valid`=0, `output_data`=0, `in_ready`=1. Reset zeroes outputs without waiting for a clock edge.
- Repeat (`DATA_IN_SEQ_REPEAT_EN`):
  - Stimulus: `repeat_n`=2.
  - Required: 12 beats with `out_idx` 0..3 three times; `out_last` only on beat 12.

Source files
------------

// File: rtl/data_in_seq_pkg.sv
// Shared constants for the mix-layer input sequencer: default sizes,
// sizing helpers and the sequencer state encoding.
package data_in_seq_pkg;

   localparam int DEF_N_LEN   = 16;
   localparam int DEF_HID_DIM = 64;
   localparam int DEF_DATA_N  = 16;

   // Slices needed to cover a vector; the last slice may be partially filled.
   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // Index width that never collapses to zero bits for single-slice builds.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

endpackage

// File: rtl/data_in_seq_slice_mux.sv
// Combinational slice selector: picks DATA_N-element slice 'idx' out of a
// HID_DIM-element vector; lanes past the end of the vector read as zero.
module slice_mux
   import data_in_seq_pkg::*;
#(
   parameter int N_LEN   = DEF_N_LEN,
   parameter int HID_DIM = DEF_HID_DIM,
   parameter int DATA_N  = DEF_DATA_N,
   localparam int N_SLICE = ceil_div(HID_DIM, DATA_N),
   localparam int IDX_W   = idx_width(N_SLICE)
)(
   input  logic [HID_DIM*N_LEN-1:0] vec,
   input  logic [IDX_W-1:0]         idx,
   output logic [DATA_N*N_LEN-1:0]  slice_data
);

   localparam int SLICE_W = DATA_N * N_LEN;
   localparam int PAD_W   = N_SLICE * SLICE_W;

   // Zero-extending the vector to a whole number of slices gives the tail padding.
   logic [PAD_W-1:0]   padded;
   logic [SLICE_W-1:0] slices [N_SLICE];

   assign padded = PAD_W'(vec);

   genvar gi;
   generate
      for (gi = 0; gi < N_SLICE; gi++) begin : g_slice
         assign slices[gi] = padded[gi*SLICE_W +: SLICE_W];
      end
   endgenerate

   // Select the slice addressed by idx; out-of-range indices yield zero.
   always_comb begin
      slice_data = '0;
      for (int s = 0; s < N_SLICE; s++) begin
         if (idx == IDX_W'(s)) slice_data = slices[s];
      end
   end

endmodule

// File: rtl/data_in_seq.sv
// Input sequencer for the mix layer: captures one hidden vector and streams
// it as DATA_N-element slices under valid/ready flow control, accepting the
// next vector on the final beat without a bubble.
// Optional feature macro: DATA_IN_SEQ_REPEAT_EN (adds repeat_n, multi-pass streaming).
module data_in_seq
   import data_in_seq_pkg::*;
#(
   parameter int N_LEN   = DEF_N_LEN,
   parameter int HID_DIM = DEF_HID_DIM,
   parameter int DATA_N  = DEF_DATA_N,
   localparam int N_SLICE = ceil_div(HID_DIM, DATA_N),
   localparam int IDX_W   = idx_width(N_SLICE)
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [HID_DIM*N_LEN-1:0] input_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_N*N_LEN-1:0]  output_data,
   output logic [IDX_W-1:0]         out_idx,
   output logic                     out_last,
`ifdef DATA_IN_SEQ_REPEAT_EN
   input  logic [7:0]               repeat_n,
`endif
   output logic                     busy
);

   localparam int VEC_W   = HID_DIM * N_LEN;
   localparam int SLICE_W = DATA_N * N_LEN;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICE - 1);

   state_t             state_reg, state_next;
   logic [VEC_W-1:0]   vec_reg, vec_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic               last_reg, last_next;
   logic [SLICE_W-1:0] data_reg, data_next;
   logic [SLICE_W-1:0] mux_data;
   logic               load_slice;
   logic               zero_out;
`ifdef DATA_IN_SEQ_REPEAT_EN
   logic [7:0]         pass_reg, pass_next;
   logic [7:0]         rep_reg, rep_next;
`endif

   // The mux looks at the vector/index that will be current next cycle, so
   // the registered slice always matches the registered index.
   slice_mux #(
      .N_LEN   (N_LEN),
      .HID_DIM (HID_DIM),
      .DATA_N  (DATA_N)
   ) u_slice_mux (
      .vec        (vec_next),
      .idx        (idx_next),
      .slice_data (mux_data)
   );

   // Next-state, capture and slice-advance decisions; clear overrides all handshakes.
   always_comb begin
      state_next = state_reg;
      vec_next   = vec_reg;
      idx_next   = idx_reg;
      last_next  = last_reg;
      load_slice = 1'b0;
      zero_out   = 1'b0;
`ifdef DATA_IN_SEQ_REPEAT_EN
      pass_next  = pass_reg;
      rep_next   = rep_reg;
`endif
      // last_reg is only ever set while streaming.
      in_ready = (state_reg == ST_IDLE) || (last_reg && out_ready);

      if (clear) begin
         state_next = ST_IDLE;
         idx_next   = '0;
         last_next  = 1'b0;
         zero_out   = 1'b1;
`ifdef DATA_IN_SEQ_REPEAT_EN
         pass_next  = 8'd0;
`endif
      end else if (in_valid && in_ready) begin
         state_next = ST_STREAM;
         vec_next   = input_data;
         idx_next   = '0;
         load_slice = 1'b1;
`ifdef DATA_IN_SEQ_REPEAT_EN
         pass_next  = 8'd0;
         rep_next   = repeat_n;
         last_next  = (N_SLICE == 1) && (repeat_n == 8'd0);
`else
         last_next  = (N_SLICE == 1);
`endif
      end else if ((state_reg == ST_STREAM) && out_ready) begin
         if (last_reg) begin
            state_next = ST_IDLE;
            idx_next   = '0;
            last_next  = 1'b0;
            zero_out   = 1'b1;
         end else begin
`ifdef DATA_IN_SEQ_REPEAT_EN
            if (idx_reg == LAST_IDX) begin
               idx_next  = '0;
               pass_next = pass_reg + 8'd1;
            end else begin
               idx_next  = idx_reg + IDX_W'(1);
            end
            last_next  = (idx_next == LAST_IDX) && (pass_next == rep_reg);
`else
            idx_next   = idx_reg + IDX_W'(1);
            last_next  = (idx_next == LAST_IDX);
`endif
            load_slice = 1'b1;
         end
      end
   end

   // Slice register update: zero on leaving STREAM, reload on advance, else hold.
   always_comb begin
      data_next = data_reg;
      if (zero_out)        data_next = '0;
      else if (load_slice) data_next = mux_data;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         vec_reg   <= '0;
         idx_reg   <= '0;
         last_reg  <= 1'b0;
         data_reg  <= '0;
`ifdef DATA_IN_SEQ_REPEAT_EN
         pass_reg  <= 8'd0;
         rep_reg   <= 8'd0;
`endif
      end else begin
         state_reg <= state_next;
         vec_reg   <= vec_next;
         idx_reg   <= idx_next;
         last_reg  <= last_next;
         data_reg  <= data_next;
`ifdef DATA_IN_SEQ_REPEAT_EN
         pass_reg  <= pass_next;
         rep_reg   <= rep_next;
`endif
      end
   end

   assign out_valid   = (state_reg == ST_STREAM);
   assign busy        = (state_reg == ST_STREAM);
   assign output_data = data_reg;
   assign out_idx     = idx_reg;
   assign out_last    = last_reg;

endmodule
